// File: rtl/cirno9_bus_pkg.sv
// Shared types for the cirno9 load/store router: FSM states and the
// address-region encoding produced by the decoder.
package cirno9_bus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SRAM_RSP = 3'd1,
    IOB_WAIT = 3'd2,
    IOB_RSP  = 3'd3,
    ERR_RSP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REG_SRAM = 2'd0,
    REG_IOB  = 2'd1,
    REG_NONE = 2'd2
  } region_e;

endpackage

// File: rtl/cirno9_addr_decode.sv
// Combinational address decoder: classifies a byte address as SRAM, one of
// the IO channel windows, or unmapped, and flags word-misaligned addresses.
module cirno9_addr_decode
  import cirno9_bus_pkg::*;
#(
  parameter int          DW              = 32,
  parameter int          AW              = 32,
  parameter int          SRAM_AW         = 12,
  parameter int          N_IOB           = 2,
  parameter logic [AW-1:0] IOB_BASE      = 32'h1000_0000,
  parameter int          IOB_STRIDE_LOG2 = 16,
  parameter int          CH_W            = 1
) (
  input  logic [AW-1:0]   adr,
  output region_e         region,
  output logic [CH_W-1:0] chan,
  output logic            misaligned
);

  localparam int            OFS_W      = $clog2(DW / 8);
  localparam logic [AW-1:0] ALIGN_MASK = AW'(DW / 8 - 1);
  localparam logic [AW-1:0] BASE_PAGE  = IOB_BASE >> IOB_STRIDE_LOG2;

  logic [AW-1:0]    page;
  logic             sram_hit;
  logic [N_IOB-1:0] iob_hit;

  assign misaligned = |(adr & ALIGN_MASK);
  assign sram_hit   = (adr >> (SRAM_AW + OFS_W)) == '0;
  assign page       = adr >> IOB_STRIDE_LOG2;

  // One window comparator per IO channel
  generate
    for (genvar gi = 0; gi < N_IOB; gi++) begin : g_iob_hit
      assign iob_hit[gi] = (page == BASE_PAGE + AW'(gi));
    end
  endgenerate

  // Region select; SRAM wins if a misconfigured IO window overlaps it
  always_comb begin
    region = REG_NONE;
    chan   = '0;
    if (sram_hit) begin
      region = REG_SRAM;
    end else begin
      for (int i = 0; i < N_IOB; i++) begin
        if (iob_hit[i]) begin
          region = REG_IOB;
          chan   = CH_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cirno9_mem_router.sv
// Load/store router between the cirno9 core memory port, one SRAM bank and
// N_IOB valid/ready IO channels with timeout. Unmapped or misaligned
// accesses get an error response.
module cirno9_mem_router
  import cirno9_bus_pkg::*;
#(
  parameter int            DW              = 32,
  parameter int            AW              = 32,
  parameter int            SRAM_AW         = 12,
  parameter int            N_IOB           = 2,
  parameter logic [AW-1:0] IOB_BASE        = 32'h1000_0000,
  parameter int            IOB_STRIDE_LOG2 = 16,
  parameter int            TIMEOUT         = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_req_val,
  output logic                       o_req_rdy,
  input  logic [DW/8-1:0]            i_req_wen,
  input  logic [AW-1:0]              i_req_adr,
  input  logic [DW-1:0]              i_req_wdat,
  output logic                       o_rsp_val,
  output logic [DW-1:0]              o_rsp_rdat,
  output logic                       o_rsp_err,
  output logic                       o_sram_en,
  output logic [DW/8-1:0]            o_sram_we,
  output logic [SRAM_AW-1:0]         o_sram_adr,
  output logic [DW-1:0]              o_sram_wdat,
  input  logic [DW-1:0]              i_sram_rdat,
  output logic [N_IOB-1:0]           o_iob_val,
  input  logic [N_IOB-1:0]           i_iob_rdy,
  output logic [DW/8-1:0]            o_iob_wen,
  output logic [IOB_STRIDE_LOG2-1:0] o_iob_adr,
  output logic [DW-1:0]              o_iob_wdat,
  input  logic [N_IOB*DW-1:0]        i_iob_rdat
);

  localparam int OFS_W = $clog2(DW / 8);
  localparam int CH_W  = (N_IOB > 1) ? $clog2(N_IOB) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e                     state;
  logic [N_IOB-1:0]           iob_val_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic [CNT_W-1:0]           cnt_inc;
  logic [DW/8-1:0]            wen_reg;
  logic [IOB_STRIDE_LOG2-1:0] adr_reg;
  logic [DW-1:0]              wdat_reg;
  logic [CH_W-1:0]            chan_reg;
  logic [DW-1:0]              rdat_reg;
  logic                       sram_rd_reg;

  region_e         dec_region;
  logic [CH_W-1:0] dec_chan;
  logic            dec_misaligned;
  logic            accept;
  logic            sram_acc;
  logic            iob_acc;
  logic            sel_rdy;
  logic [DW-1:0]   sel_rdat;
  logic [DW-1:0]   ch_rdat [N_IOB];

  cirno9_addr_decode #(
    .DW              (DW),
    .AW              (AW),
    .SRAM_AW         (SRAM_AW),
    .N_IOB           (N_IOB),
    .IOB_BASE        (IOB_BASE),
    .IOB_STRIDE_LOG2 (IOB_STRIDE_LOG2),
    .CH_W            (CH_W)
  ) u_decode (
    .adr        (i_req_adr),
    .region     (dec_region),
    .chan       (dec_chan),
    .misaligned (dec_misaligned)
  );

  // Split the flat per-channel read data bus into per-channel words
  generate
    for (genvar gi = 0; gi < N_IOB; gi++) begin : g_ch_rdat
      assign ch_rdat[gi] = i_iob_rdat[gi*DW +: DW];
    end
  endgenerate

  assign o_req_rdy = (state == IDLE) || (state == SRAM_RSP);
  assign accept    = i_req_val && o_req_rdy;
  assign sram_acc  = accept && !dec_misaligned && (dec_region == REG_SRAM);
  assign iob_acc   = accept && !dec_misaligned && (dec_region == REG_IOB);
  assign sel_rdy   = i_iob_rdy[chan_reg];
  assign sel_rdat  = ch_rdat[chan_reg];
  assign cnt_inc   = cnt_reg + 1'b1;

  // SRAM strobes go out in the accept cycle so the bank runs one access per cycle
  always_comb begin
    o_sram_en   = sram_acc;
    o_sram_we   = '0;
    o_sram_adr  = '0;
    o_sram_wdat = '0;
    if (sram_acc) begin
      o_sram_we   = i_req_wen;
      o_sram_adr  = i_req_adr[OFS_W +: SRAM_AW];
      o_sram_wdat = i_req_wdat;
    end
  end

  assign o_iob_val  = iob_val_reg;
  assign o_iob_wen  = wen_reg;
  assign o_iob_adr  = adr_reg;
  assign o_iob_wdat = wdat_reg;

  // Response decode from the registered state; SRAM data passes straight through
  always_comb begin
    o_rsp_val  = (state == SRAM_RSP) || (state == IOB_RSP) || (state == ERR_RSP);
    o_rsp_err  = (state == ERR_RSP);
    o_rsp_rdat = '0;
    if (state == SRAM_RSP && sram_rd_reg) begin
      o_rsp_rdat = i_sram_rdat;
    end else if (state == IOB_RSP) begin
      o_rsp_rdat = rdat_reg;
    end
  end

  // Router FSM with the IO handshake latches and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      iob_val_reg <= '0;
      cnt_reg     <= '0;
      wen_reg     <= '0;
      adr_reg     <= '0;
      wdat_reg    <= '0;
      chan_reg    <= '0;
      rdat_reg    <= '0;
      sram_rd_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, SRAM_RSP: begin
          if (accept) begin
            if (sram_acc) begin
              state       <= SRAM_RSP;
              sram_rd_reg <= (i_req_wen == '0);
            end else if (iob_acc) begin
              state       <= IOB_WAIT;
              wen_reg     <= i_req_wen;
              adr_reg     <= i_req_adr[IOB_STRIDE_LOG2-1:0];
              wdat_reg    <= i_req_wdat;
              chan_reg    <= dec_chan;
              iob_val_reg <= N_IOB'(1) << dec_chan;
              cnt_reg     <= '0;
            end else begin
              state <= ERR_RSP;
            end
          end else begin
            state <= IDLE;
          end
        end
        IOB_WAIT: begin
          if (sel_rdy) begin
            // Ready on the final counted cycle still completes the access
            state       <= IOB_RSP;
            iob_val_reg <= '0;
            rdat_reg    <= (wen_reg == '0) ? sel_rdat : '0;
          end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
            state       <= ERR_RSP;
            iob_val_reg <= '0;
          end else begin
            cnt_reg <= cnt_inc;
            // Valid is held for exactly TIMEOUT cycles
            if (cnt_inc == CNT_W'(TIMEOUT)) begin
              iob_val_reg <= '0;
            end
          end
        end
        IOB_RSP: state <= IDLE;
        ERR_RSP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cirno9_mem_router.sv
// Directed bench for cirno9_mem_router: SRAM, IO handshake, timeout,
// error decode and mid-transaction reset.
module tb_cirno9_mem_router;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int SAW   = 12;
  localparam int NIOB  = 2;
  localparam int SLOG2 = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_req_val;
  logic              o_req_rdy;
  logic [3:0]        i_req_wen;
  logic [AW-1:0]     i_req_adr;
  logic [DW-1:0]     i_req_wdat;
  logic              o_rsp_val;
  logic [DW-1:0]     o_rsp_rdat;
  logic              o_rsp_err;
  logic              o_sram_en;
  logic [3:0]        o_sram_we;
  logic [SAW-1:0]    o_sram_adr;
  logic [DW-1:0]     o_sram_wdat;
  logic [DW-1:0]     i_sram_rdat;
  logic [NIOB-1:0]   o_iob_val;
  logic [NIOB-1:0]   i_iob_rdy;
  logic [3:0]        o_iob_wen;
  logic [SLOG2-1:0]  o_iob_adr;
  logic [DW-1:0]     o_iob_wdat;
  logic [NIOB*DW-1:0] i_iob_rdat;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [0:(1<<SAW)-1];

  always #5 clk = ~clk;

  cirno9_mem_router #(
    .DW(DW), .AW(AW), .SRAM_AW(SAW), .N_IOB(NIOB),
    .IOB_BASE(32'h1000_0000), .IOB_STRIDE_LOG2(SLOG2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_val(i_req_val), .o_req_rdy(o_req_rdy), .i_req_wen(i_req_wen),
    .i_req_adr(i_req_adr), .i_req_wdat(i_req_wdat),
    .o_rsp_val(o_rsp_val), .o_rsp_rdat(o_rsp_rdat), .o_rsp_err(o_rsp_err),
    .o_sram_en(o_sram_en), .o_sram_we(o_sram_we), .o_sram_adr(o_sram_adr),
    .o_sram_wdat(o_sram_wdat), .i_sram_rdat(i_sram_rdat),
    .o_iob_val(o_iob_val), .i_iob_rdy(i_iob_rdy), .o_iob_wen(o_iob_wen),
    .o_iob_adr(o_iob_adr), .o_iob_wdat(o_iob_wdat), .i_iob_rdat(i_iob_rdat)
  );

  // SRAM model: byte-enabled write, registered read
  always @(posedge clk) begin
    if (o_sram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (o_sram_we[b]) mem[o_sram_adr][8*b +: 8] <= o_sram_wdat[8*b +: 8];
      end
      i_sram_rdat <= mem[o_sram_adr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] wen, input logic [31:0] adr, input logic [31:0] wdat);
    i_req_val  = 1'b1;
    i_req_wen  = wen;
    i_req_adr  = adr;
    i_req_wdat = wdat;
  endtask

  task automatic idle_req();
    i_req_val  = 1'b0;
    i_req_wen  = '0;
    i_req_adr  = '0;
    i_req_wdat = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_req();
    i_iob_rdy   = '0;
    i_iob_rdat  = '0;
    i_sram_rdat = '0;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA5A5_0000 + i;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", o_req_rdy, 1);
    check("rst_rsp_val", o_rsp_val, 0);
    check("rst_rsp_err", o_rsp_err, 0);
    check("rst_rsp_rdat", o_rsp_rdat, 0);
    check("rst_iob_val", o_iob_val, 0);
    check("rst_sram_en", o_sram_en, 0);
    rst_n = 1'b1;
    tick();

    // SRAM write then read back
    req(4'hF, 32'h10, 32'hDEAD_BEEF);
    #1;
    check("sw_en", o_sram_en, 1);
    check("sw_we", o_sram_we, 4'hF);
    check("sw_adr", o_sram_adr, 4);
    check("sw_wdat", o_sram_wdat, 32'hDEAD_BEEF);
    tick();
    idle_req();
    #1;
    check("sw_rsp_val", o_rsp_val, 1);
    check("sw_rsp_err", o_rsp_err, 0);
    check("sw_rsp_rdat", o_rsp_rdat, 0);
    $display("txn sram write adr=0x10 data=deadbeef");
    tick();
    req(4'h0, 32'h10, 32'h0);
    #1;
    check("sr_en", o_sram_en, 1);
    check("sr_we", o_sram_we, 0);
    tick();
    idle_req();
    #1;
    check("sr_rsp_val", o_rsp_val, 1);
    check("sr_rsp_err", o_rsp_err, 0);
    check("sr_rsp_rdat", o_rsp_rdat, 32'hDEAD_BEEF);
    $display("txn sram read adr=0x10 data=%0h", o_rsp_rdat);
    tick();

    // Four back-to-back SRAM reads
    for (int i = 0; i < 4; i++) begin
      req(4'h0, 32'(4 * i), 32'h0);
      #1;
      check("b2b_rdy", o_req_rdy, 1);
      if (i > 0) begin
        check("b2b_rsp_val", o_rsp_val, 1);
        check("b2b_rdat", o_rsp_rdat, 32'hA5A5_0000 + 32'(i - 1));
      end
      tick();
    end
    idle_req();
    #1;
    check("b2b_last_val", o_rsp_val, 1);
    check("b2b_last_rdat", o_rsp_rdat, 32'hA5A5_0003);
    tick();
    check("b2b_done_val", o_rsp_val, 0);
    $display("txn sram 4x back-to-back read");

    // IO read on channel 1, ready after 3 wait cycles
    i_iob_rdat = {32'h0000_0055, 32'h0000_00AA};
    req(4'h0, 32'h1001_0004, 32'h0);
    #1;
    check("io_acc_rdy", o_req_rdy, 1);
    check("io_acc_sram", o_sram_en, 0);
    tick();
    idle_req();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) i_iob_rdy = 2'b10;
      #1;
      check("io_val", o_iob_val, 2'b10);
      check("io_adr", o_iob_adr, 4);
      check("io_rsp_wait", o_rsp_val, 0);
      check("io_rdy_busy", o_req_rdy, 0);
      tick();
    end
    i_iob_rdy = '0;
    #1;
    check("io_rsp_val", o_rsp_val, 1);
    check("io_rsp_err", o_rsp_err, 0);
    check("io_rsp_rdat", o_rsp_rdat, 32'h55);
    check("io_val_done", o_iob_val, 0);
    $display("txn iob1 read adr=0x10010004 data=%0h", o_rsp_rdat);
    tick();

    // Timeout on channel 0
    req(4'h0, 32'h1000_0000, 32'h0);
    tick();
    idle_req();
    for (int c = 1; c <= 8; c++) begin
      #1;
      check("to_val", o_iob_val, 2'b01);
      check("to_rsp_wait", o_rsp_val, 0);
      tick();
    end
    #1;
    check("to_val_drop", o_iob_val, 0);
    check("to_rsp_c9", o_rsp_val, 0);
    tick();
    check("to_rsp_val", o_rsp_val, 1);
    check("to_rsp_err", o_rsp_err, 1);
    check("to_rsp_rdat", o_rsp_rdat, 0);
    $display("txn iob0 read timeout err=%0b", o_rsp_err);
    tick();
    check("to_after_val", o_rsp_val, 0);
    check("to_after_rdy", o_req_rdy, 1);

    // IO write on channel 0, ready immediately
    req(4'hF, 32'h1000_0008, 32'hCAFE_F00D);
    tick();
    idle_req();
    i_iob_rdy = 2'b01;
    #1;
    check("iw_val", o_iob_val, 2'b01);
    check("iw_wen", o_iob_wen, 4'hF);
    check("iw_adr", o_iob_adr, 8);
    check("iw_wdat", o_iob_wdat, 32'hCAFE_F00D);
    tick();
    i_iob_rdy = '0;
    #1;
    check("iw_rsp_val", o_rsp_val, 1);
    check("iw_rsp_err", o_rsp_err, 0);
    check("iw_rsp_rdat", o_rsp_rdat, 0);
    $display("txn iob0 write adr=0x10000008 data=cafef00d");
    tick();

    // Unmapped then misaligned
    req(4'h0, 32'h2000_0000, 32'h0);
    #1;
    check("um_sram_en", o_sram_en, 0);
    tick();
    idle_req();
    #1;
    check("um_rsp_val", o_rsp_val, 1);
    check("um_rsp_err", o_rsp_err, 1);
    check("um_iob_val", o_iob_val, 0);
    $display("txn unmapped read adr=0x20000000 err=%0b", o_rsp_err);
    tick();
    req(4'h0, 32'h0000_0002, 32'h0);
    #1;
    check("ma_sram_en", o_sram_en, 0);
    tick();
    idle_req();
    #1;
    check("ma_rsp_val", o_rsp_val, 1);
    check("ma_rsp_err", o_rsp_err, 1);
    check("ma_rsp_rdat", o_rsp_rdat, 0);
    check("ma_iob_val", o_iob_val, 0);
    $display("txn misaligned read adr=0x2 err=%0b", o_rsp_err);
    tick();

    // Reset during IOB_WAIT
    req(4'h0, 32'h1001_0000, 32'h0);
    tick();
    idle_req();
    #1;
    check("rw_val", o_iob_val, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rw_val_drop", o_iob_val, 0);
    check("rw_rsp_val", o_rsp_val, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rw_post_rsp", o_rsp_val, 0);
      check("rw_post_rdy", o_req_rdy, 1);
      tick();
    end
    $display("txn reset during iob wait");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
